pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Central stall/flush controller for the 5-stage MIPS pipeline. It drives the clock-enable and bubble-insert (synchronous clear-to-NOP) controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It arbitrates four hazard sources: data-memory wait, taken branch, load-use and multi-cycle mult/div. It also keeps a saturating stall-cycle performance counter.

## Interface
- MULDIV_CYCLES, 4, total EX-stage occupancy of a mult/div instruction in cycles; legal range 2..255
- clk  input  1  pipeline clock, rising edge
- rst  input  1  asynchronous, active-high reset
- id_rs  input  5  rs field of the instruction in ID
- id_rt  input  5  rt field of the instruction in ID
- id_uses_rs  input  1  ID instruction reads rs
- id_uses_rt  input  1  ID instruction reads rt
- id_muldiv  input  1  ID instruction is mult/multu/div/divu
- ex_mem_read  input  1  EX instruction is a load
- ex_rt  input  5  destination register of the EX load
- ex_branch_taken  input  1  branch/jump resolved taken in EX
- mem_wait  input  1  data memory not ready; freeze the whole pipeline
- pc_ce, ifid_ce, idex_ce, exmem_ce, memwb_ce  output  1 each  register clock-enables
- ifid_clr, idex_clr, exmem_clr  output  1 each  load NOP instead of D on the next enabled edge
- muldiv_busy  output  1  high while in state MDIV
- stall_count  output  16  saturating count of cycles with pc_ce=0

## Operation
- State register: RUN or MDIV, plus an 8-bit down-counter cnt.
- All control outputs are Mealy-combinational from state and inputs, so they act on the same clock edge.
- While rst=1, every CE and clr output is 0.
- Load-use hazard lu is true when all of these hold:
  - ex_mem_read=1 and ex_rt≠0
  - (id_uses_rs and id_rs==ex_rt) or (id_uses_rt and id_rt==ex_rt)
- RUN, evaluated in priority order:
  1. mem_wait=1: all CE=0, all clr=0, state unchanged.
  2. ex_branch_taken=1: all CE=1, ifid_clr=1, idex_clr=1. This squashes the two wrong-path instructions. Any lu or id_muldiv is ignored.
  3. lu=1: pc_ce=0, ifid_ce=0; idex_ce=1 with idex_clr=1 (bubble); exmem_ce=1, memwb_ce=1. A pending id_muldiv is accepted the following cycle.
  4. id_muldiv=1: normal advance (all CE=1, no clr). The mult/div moves into EX. Go to MDIV with cnt=MULDIV_CYCLES-1.
  5. Otherwise: all CE=1, all clr=0.
- MDIV:
  - Outputs: pc_ce=ifid_ce=idex_ce=0; exmem_ce=1 with exmem_clr=1; memwb_ce=1; muldiv_busy=1.
  - ex_branch_taken, lu and id_muldiv are ignored.
  - mem_wait=1 overrides: all CE=0, all clr=0, cnt holds.
  - Otherwise cnt decrements each cycle. Return to RUN on the edge where cnt==1.
  - Net effect: MDIV lasts MULDIV_CYCLES-1 unfrozen cycles.
- stall_count:
  - Increments by 1 on each edge where rst=0 and pc_ce=0. This covers mem_wait, lu and MDIV cycles.
  - Saturates at 16'hFFFF.
  - Cleared only by reset.

## Timing
- Reset values:
  - state=RUN, cnt=0, stall_count=0, muldiv_busy=0.
  - All CE and clr outputs are 0 while rst is high.
- After rst deasserts, the first rising edge is a normal RUN cycle.
- Reset asserted mid-MDIV aborts the sequence immediately and asynchronously (state=RUN, cnt=0).
- Load-use stall: exactly 1 cycle; the load has reached MEM by the next cycle, so lu clears.
- Branch flush penalty: 2 instructions, 0 stall cycles.
- Mult/div: occupies EX for MULDIV_CYCLES unfrozen cycles, counted from the acceptance edge.
- Simultaneous events:
  - mem_wait dominates everything and freezes the counter.
  - Branch dominates lu and id_muldiv.
  - lu dominates id_muldiv.
- Combinational path: inputs to outputs must settle within the same cycle; no registered output delay.

## Test plan
- Reset: hold rst, apply random inputs → all CE=0, all clr=0, stall_count=0. Release rst with no hazards → all CE=1 on the next cycle.
- Load-use: ex_mem_read=1, ex_rt=5, id_rs=5, id_uses_rs=1 for one cycle → pc_ce=ifid_ce=0, idex_clr=1, stall_count=1. Repeat with ex_rt=0 → no stall.
- Branch vs load-use: ex_branch_taken=1 together with an lu condition → all CE=1, ifid_clr=idex_clr=1, stall_count unchanged.
- Mult/div with MULDIV_CYCLES=4: id_muldiv pulse →
  - muldiv_busy high for exactly 3 cycles, with exmem_clr=1 and pc_ce=0 throughout;
  - then RUN; stall_count=3.
- mem_wait inside MDIV: assert mem_wait for 2 cycles mid-sequence → all CE=0, cnt frozen, MDIV extended by 2 cycles, stall_count=5.
- Saturation and reset abort:
  - Force stall_count to 16'hFFFE, then hold mem_wait 3 cycles → reads 16'hFFFF.
  - Assert rst mid-MDIV → state=RUN and muldiv_busy=0 immediately.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the MIPS pipeline datapath and the
// central stall/flush controller. The datapath side (master) reports the
// hazard sources; the controller side (slave) returns register clock
// enables, bubble-insert controls and status.
interface pipe_hazard_ctrl_if;
    // Hazard sources reported by the datapath
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic        id_muldiv;
    logic        ex_mem_read;
    logic [4:0]  ex_rt;
    logic        ex_branch_taken;
    logic        mem_wait;

    // Pipeline register controls returned by the controller
    logic        pc_ce;
    logic        ifid_ce;
    logic        idex_ce;
    logic        exmem_ce;
    logic        memwb_ce;
    logic        ifid_clr;
    logic        idex_clr;
    logic        exmem_clr;
    logic        muldiv_busy;
    logic [15:0] stall_count;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, id_muldiv,
               ex_mem_read, ex_rt, ex_branch_taken, mem_wait,
        input  pc_ce, ifid_ce, idex_ce, exmem_ce, memwb_ce,
               ifid_clr, idex_clr, exmem_clr, muldiv_busy, stall_count
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_muldiv,
               ex_mem_read, ex_rt, ex_branch_taken, mem_wait,
        output pc_ce, ifid_ce, idex_ce, exmem_ce, memwb_ce,
               ifid_clr, idex_clr, exmem_clr, muldiv_busy, stall_count
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage MIPS pipeline.
// Arbitrates data-memory wait, taken branch, load-use and multi-cycle
// mult/div hazards into per-stage clock enables and bubble inserts.
// Controls are Mealy outputs so they act on the very next clock edge.
// A saturating counter tracks cycles in which the PC was held.
module pipe_hazard_ctrl #(
    parameter int MULDIV_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    pipe_hazard_ctrl_if.slave   bus
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_MDIV = 1'b1
    } state_e;

    localparam logic [7:0]  MDIV_LOAD = 8'(MULDIV_CYCLES - 1);
    localparam logic [15:0] STALL_MAX = 16'hFFFF;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic        lu_s;
    logic        pc_ce_s, ifid_ce_s, idex_ce_s, exmem_ce_s, memwb_ce_s;
    logic        ifid_clr_s, idex_clr_s, exmem_clr_s;
    logic        busy_s;

    // Load-use detect: EX load writes a register that the ID instruction reads
    always_comb begin
        lu_s = 1'b0;
        if (bus.ex_mem_read && (bus.ex_rt != 5'd0)) begin
            lu_s = (bus.id_uses_rs && (bus.id_rs == bus.ex_rt)) ||
                   (bus.id_uses_rt && (bus.id_rt == bus.ex_rt));
        end else begin
            lu_s = 1'b0;
        end
    end

    // Hazard arbitration: next state and same-cycle register controls
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_ce_s     = 1'b0;
        ifid_ce_s   = 1'b0;
        idex_ce_s   = 1'b0;
        exmem_ce_s  = 1'b0;
        memwb_ce_s  = 1'b0;
        ifid_clr_s  = 1'b0;
        idex_clr_s  = 1'b0;
        exmem_clr_s = 1'b0;
        busy_s      = 1'b0;

        if (rst) begin
            // Pipeline held completely quiet while reset is applied
            state_d = ST_RUN;
            cnt_d   = 8'd0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (bus.mem_wait) begin
                        // Whole pipeline frozen, nothing changes
                        state_d = ST_RUN;
                    end else if (bus.ex_branch_taken) begin
                        // Squash the two wrong-path instructions in IF/ID and ID/EX
                        pc_ce_s    = 1'b1;
                        ifid_ce_s  = 1'b1;
                        idex_ce_s  = 1'b1;
                        exmem_ce_s = 1'b1;
                        memwb_ce_s = 1'b1;
                        ifid_clr_s = 1'b1;
                        idex_clr_s = 1'b1;
                    end else if (lu_s) begin
                        // Hold IF/ID, drop a bubble into EX while the load moves on
                        idex_ce_s  = 1'b1;
                        idex_clr_s = 1'b1;
                        exmem_ce_s = 1'b1;
                        memwb_ce_s = 1'b1;
                    end else if (bus.id_muldiv) begin
                        // Mult/div enters EX now; back-end keeps draining afterwards
                        pc_ce_s    = 1'b1;
                        ifid_ce_s  = 1'b1;
                        idex_ce_s  = 1'b1;
                        exmem_ce_s = 1'b1;
                        memwb_ce_s = 1'b1;
                        state_d    = ST_MDIV;
                        cnt_d      = MDIV_LOAD;
                    end else begin
                        pc_ce_s    = 1'b1;
                        ifid_ce_s  = 1'b1;
                        idex_ce_s  = 1'b1;
                        exmem_ce_s = 1'b1;
                        memwb_ce_s = 1'b1;
                    end
                end
                ST_MDIV: begin
                    busy_s = 1'b1;
                    if (bus.mem_wait) begin
                        // Freeze also freezes the mult/div countdown
                        cnt_d = cnt_q;
                    end else begin
                        // Front end held, bubbles flow out of EX behind the mult/div
                        exmem_ce_s  = 1'b1;
                        exmem_clr_s = 1'b1;
                        memwb_ce_s  = 1'b1;
                        cnt_d       = cnt_q - 8'd1;
                        if (cnt_q <= 8'd1) begin
                            state_d = ST_RUN;
                            cnt_d   = 8'd0;
                        end else begin
                            state_d = ST_MDIV;
                        end
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = 8'd0;
                end
            endcase
        end
    end

    // Saturating next value of the stall counter
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_ce_s && (stall_cnt_q != STALL_MAX)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Controller state and mult/div countdown; reset aborts any sequence
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Stall-cycle performance counter, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.pc_ce       = pc_ce_s;
    assign bus.ifid_ce     = ifid_ce_s;
    assign bus.idex_ce     = idex_ce_s;
    assign bus.exmem_ce    = exmem_ce_s;
    assign bus.memwb_ce    = memwb_ce_s;
    assign bus.ifid_clr    = ifid_clr_s;
    assign bus.idex_clr    = idex_clr_s;
    assign bus.exmem_clr   = exmem_clr_s;
    assign bus.muldiv_busy = busy_s;
    assign bus.stall_count = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed hazard scenarios,
// randomized traffic and counter saturation, all compared against a
// cycle-level behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;

    localparam int MD = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    // Reference model state: remaining unfrozen mult/div cycles and stall total
    int   md_left;
    int   m_stall;

    pipe_hazard_ctrl_if bus ();

    pipe_hazard_ctrl #(.MULDIV_CYCLES(MD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic apply(input logic mw, input logic br, input logic emr, input logic [4:0] ert,
                         input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                         input logic urt, input logic md);
        bus.mem_wait        = mw;
        bus.ex_branch_taken = br;
        bus.ex_mem_read     = emr;
        bus.ex_rt           = ert;
        bus.id_rs           = rs;
        bus.id_rt           = rt;
        bus.id_uses_rs      = urs;
        bus.id_uses_rt      = urt;
        bus.id_muldiv       = md;
    endtask

    task automatic idle();
        apply(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Check this cycle's outputs against the model, then advance the model past the edge
    task automatic step(input string tag);
        logic [8:0] e;   // {pc,ifid,idex,exmem,memwb,ifid_clr,idex_clr,exmem_clr,busy}
        logic [8:0] got;
        bit         lu;
        #1;
        if (rst) begin
            md_left = 0;
            m_stall = 0;
        end
        lu = bus.ex_mem_read && (bus.ex_rt != 5'd0) &&
             ((bus.id_uses_rs && bus.id_rs == bus.ex_rt) ||
              (bus.id_uses_rt && bus.id_rt == bus.ex_rt));
        if (rst)                      e = 9'b000000000;
        else if (md_left > 0)         e = bus.mem_wait ? 9'b000000001 : 9'b000110011;
        else if (bus.mem_wait)        e = 9'b000000000;
        else if (bus.ex_branch_taken) e = 9'b111111100;
        else if (lu)                  e = 9'b001110100;
        else                          e = 9'b111110000;
        got = {bus.pc_ce, bus.ifid_ce, bus.idex_ce, bus.exmem_ce, bus.memwb_ce,
               bus.ifid_clr, bus.idex_clr, bus.exmem_clr, bus.muldiv_busy};
        chk({tag, "_ctl"}, 32'(got), 32'(e));
        chk({tag, "_cnt"}, 32'(bus.stall_count), 32'(m_stall));
        if (!rst) begin
            if (e[8] == 1'b0 && m_stall < 65535) m_stall = m_stall + 1;
            if (md_left > 0) begin
                if (!bus.mem_wait) md_left = md_left - 1;
            end else if (!bus.mem_wait && !bus.ex_branch_taken && !lu && bus.id_muldiv) begin
                md_left = MD - 1;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        md_left  = 0;
        m_stall  = 0;
        rst      = 1'b1;
        idle();
        @(negedge clk);

        // Reset held with random inputs: everything quiet
        for (int i = 0; i < 6; i++) begin
            apply(1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), 5'($urandom),
                  5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            step("rst");
        end
        rst = 1'b0;
        idle();
        step("rel");

        // Load-use stall of exactly one cycle
        apply(1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd9, 1'b1, 1'b0, 1'b0);
        step("lu");
        chk("lu_stall", 32'(bus.stall_count), 32'd1);
        // Same pattern against r0 is not a hazard
        apply(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0);
        step("lu_r0");
        chk("lu_r0_stall", 32'(bus.stall_count), 32'd1);
        // Hazard via rt only
        apply(1'b0, 1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b1, 1'b0);
        step("lu_rt");
        // Branch beats load-use and mult/div
        apply(1'b0, 1'b1, 1'b1, 5'd5, 5'd5, 5'd9, 1'b1, 1'b0, 1'b1);
        step("br_lu");
        chk("br_stall", 32'(bus.stall_count), 32'd2);

        // Mult/div pulse: three busy cycles afterwards
        apply(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        step("md_acc");
        idle();
        for (int i = 0; i < 3; i++) step("md_busy");
        step("md_done");
        chk("md_stall", 32'(bus.stall_count), 32'd5);

        // mem_wait for two cycles inside MDIV extends it by two
        apply(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        step("mw_acc");
        idle();
        step("mw_b0");
        bus.mem_wait = 1'b1;
        step("mw_f0");
        step("mw_f1");
        bus.mem_wait = 1'b0;
        step("mw_b1");
        step("mw_b2");
        step("mw_done");
        chk("mw_stall", 32'(bus.stall_count), 32'd10);

        // Reset in the middle of a mult/div aborts it at once
        apply(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        step("ab_acc");
        idle();
        step("ab_busy");
        rst = 1'b1;
        #1;
        chk("ab_busy_now", 32'(bus.muldiv_busy), 32'd0);
        step("ab_rst");
        rst = 1'b0;
        step("ab_run");

        // Randomized traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            apply($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, 1'($urandom),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom), 1'($urandom), $urandom_range(0, 5) == 0);
            step("rnd");
        end

        // Saturation: hold mem_wait past the counter limit
        rst = 1'b1;
        idle();
        step("sat_rst");
        rst = 1'b0;
        bus.mem_wait = 1'b1;
        for (int i = 0; i < 65540; i++) step("sat");
        chk("sat_max", 32'(bus.stall_count), 32'h0000FFFF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
